// File: rtl/axi4_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | axi4_pkg : shared AXI4 burst/response encodings and slave FSM states  |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // WRAP and the reserved encoding are accepted on the bus but answered with SLVERR
  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_slave_mem_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | axi4_slave_mem_if : AXI4 five-channel bundle with master/slave views  |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
interface axi4_slave_mem_if #(
  parameter int data_wid = 64,
  parameter int adr_wid  = 32,
  parameter int id_wid   = 8
);

  logic [id_wid-1:0]     AWID_a;
  logic [adr_wid-1:0]    AWADDR_a;
  logic [7:0]            AWLEN_a;
  logic [2:0]            AWSIZE_a;
  logic [1:0]            AWBURST_a;
  logic                  AWVALID_a;
  logic                  AWREADY_a;

  logic [id_wid-1:0]     WID_a;
  logic [data_wid-1:0]   WDATA_a;
  logic [data_wid/8-1:0] WSTRB_a;
  logic                  WLAST_a;
  logic                  WVALID_a;
  logic                  WREADY_a;

  logic [id_wid-1:0]     BID_a;
  logic [1:0]            BRESP_a;
  logic                  BVALID_a;
  logic                  BREADY_a;

  logic [id_wid-1:0]     ARID_a;
  logic [adr_wid-1:0]    ARADDR_a;
  logic [7:0]            ARLEN_a;
  logic [2:0]            ARSIZE_a;
  logic [1:0]            ARBURST_a;
  logic                  ARVALID_a;
  logic                  ARREADY_a;

  logic [id_wid-1:0]     RID_a;
  logic [data_wid-1:0]   RDATA_a;
  logic [1:0]            RRESP_a;
  logic                  RLAST_a;
  logic                  RVALID_a;
  logic                  RREADY_a;

  modport slave (
    input  AWID_a, AWADDR_a, AWLEN_a, AWSIZE_a, AWBURST_a, AWVALID_a,
    output AWREADY_a,
    input  WID_a, WDATA_a, WSTRB_a, WLAST_a, WVALID_a,
    output WREADY_a,
    output BID_a, BRESP_a, BVALID_a,
    input  BREADY_a,
    input  ARID_a, ARADDR_a, ARLEN_a, ARSIZE_a, ARBURST_a, ARVALID_a,
    output ARREADY_a,
    output RID_a, RDATA_a, RRESP_a, RLAST_a, RVALID_a,
    input  RREADY_a
  );

  modport master (
    output AWID_a, AWADDR_a, AWLEN_a, AWSIZE_a, AWBURST_a, AWVALID_a,
    input  AWREADY_a,
    output WID_a, WDATA_a, WSTRB_a, WLAST_a, WVALID_a,
    input  WREADY_a,
    input  BID_a, BRESP_a, BVALID_a,
    output BREADY_a,
    output ARID_a, ARADDR_a, ARLEN_a, ARSIZE_a, ARBURST_a, ARVALID_a,
    input  ARREADY_a,
    input  RID_a, RDATA_a, RRESP_a, RLAST_a, RVALID_a,
    output RREADY_a
  );

endinterface
`default_nettype wire

// File: rtl/axi4_slave_ram.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | axi4_slave_ram : simple dual-port RAM, byte-enable write, reg. read   |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module axi4_slave_ram
  import axi4_pkg::*;
#(
  parameter int data_wid  = 64,
  parameter int mem_depth = 256,
  parameter int idx_wid   = $clog2(mem_depth)
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  wr_en,
  input  wire logic [idx_wid-1:0]    wr_addr,
  input  wire logic [data_wid-1:0]   wr_data,
  input  wire logic [data_wid/8-1:0] wr_strb,
  input  wire logic                  rd_en,
  input  wire logic [idx_wid-1:0]    rd_addr,
  input  wire logic                  rd_zero,
  output logic      [data_wid-1:0]   rd_data
);

  logic [data_wid-1:0] mem [mem_depth];

  // Array is deliberately outside the reset domain so contents survive rst
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < data_wid/8; b++) begin
        if (wr_strb[b]) begin
          mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Read-before-write: a same-cycle write lands after this sample
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_zero ? '0 : mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi4_slave_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | axi4_slave_mem : AXI4 slave memory, independent write and read FSMs   |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module axi4_slave_mem
  import axi4_pkg::*;
#(
  parameter int data_wid  = 64,
  parameter int adr_wid   = 32,
  parameter int id_wid    = 8,
  parameter int mem_depth = 256
) (
  input wire logic         clk,
  input wire logic         rst,
  axi4_slave_mem_if.slave  bus
);

  localparam int                 STRB_W      = data_wid / 8;
  localparam int                 BSH         = $clog2(STRB_W);
  localparam int                 IDX_W       = $clog2(mem_depth);
  localparam logic [adr_wid-1:0] BEAT_BYTES  = adr_wid'(STRB_W);
  localparam logic [adr_wid-1:0] DEPTH_WORDS = adr_wid'(mem_depth);
  localparam logic [2:0]         FULL_SIZE   = 3'(BSH);

  function automatic logic out_of_range(input logic [adr_wid-1:0] a);
    return (a >> BSH) >= DEPTH_WORDS;
  endfunction

  // INCR stops advancing once past the array, so an overrun stays an error
  function automatic logic [adr_wid-1:0] next_addr(input logic [adr_wid-1:0] a,
                                                   input logic [1:0]         burst);
    if (burst == BURST_INCR && !out_of_range(a)) begin
      return a + BEAT_BYTES;
    end
    return a;
  endfunction

  // ---------------- write channel ----------------
  wr_state_t           wr_state, wr_next;
  logic                aw_hs, w_hs, wr_en, w_beat_err;
  logic [id_wid-1:0]   w_id;
  logic [adr_wid-1:0]  w_addr;
  logic [7:0]          w_len;
  logic [1:0]          w_burst;
  logic [8:0]          w_cnt;
  logic                w_cfg_err, w_err;

  always_ff @(posedge clk) begin
    if (rst) wr_state <= W_IDLE;
    else     wr_state <= wr_next;
  end

  always_comb begin
    wr_next       = wr_state;
    bus.AWREADY_a = 1'b0;
    bus.WREADY_a  = 1'b0;
    bus.BVALID_a  = 1'b0;
    case (wr_state)
      W_IDLE: begin
        bus.AWREADY_a = !rst;
        if (bus.AWVALID_a) wr_next = W_DATA;
      end
      W_DATA: begin
        bus.WREADY_a = !rst;
        if (bus.WVALID_a && bus.WLAST_a) wr_next = W_RESP;
      end
      W_RESP: begin
        bus.BVALID_a = !rst;
        if (bus.BREADY_a) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  assign aw_hs = bus.AWVALID_a & bus.AWREADY_a;
  assign w_hs  = bus.WVALID_a & bus.WREADY_a;

  // A beat past AWLEN+1 is an error beat as well, so it never reaches memory
  assign w_beat_err = w_cfg_err | out_of_range(w_addr) | (w_cnt > {1'b0, w_len});
  assign wr_en      = w_hs & ~w_beat_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_id      <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_burst   <= BURST_FIXED;
      w_cnt     <= '0;
      w_cfg_err <= 1'b0;
      w_err     <= 1'b0;
    end else if (aw_hs) begin
      w_id      <= bus.AWID_a;
      w_addr    <= bus.AWADDR_a;
      w_len     <= bus.AWLEN_a;
      w_burst   <= bus.AWBURST_a;
      w_cnt     <= '0;
      w_cfg_err <= !burst_supported(bus.AWBURST_a) || (bus.AWSIZE_a != FULL_SIZE);
      w_err     <= !burst_supported(bus.AWBURST_a) || (bus.AWSIZE_a != FULL_SIZE);
    end else if (w_hs) begin
      w_addr <= next_addr(w_addr, w_burst);
      w_cnt  <= (&w_cnt) ? w_cnt : w_cnt + 9'd1;
      w_err  <= w_err | w_beat_err | (bus.WLAST_a && (w_cnt != {1'b0, w_len}));
    end
  end

  assign bus.BID_a   = w_id;
  assign bus.BRESP_a = w_err ? RESP_SLVERR : RESP_OKAY;

  // ---------------- read channel ----------------
  rd_state_t           rd_state, rd_next;
  logic                ar_hs, r_hs, ar_cfg_err, rd_en, rd_zero;
  logic [adr_wid-1:0]  r_addr, r_next, rd_addr;
  logic [id_wid-1:0]   r_id;
  logic [7:0]          r_len, r_cnt;
  logic [1:0]          r_burst;
  logic                r_cfg_err, r_err, r_last;
  logic [data_wid-1:0] rd_data;

  always_ff @(posedge clk) begin
    if (rst) rd_state <= R_IDLE;
    else     rd_state <= rd_next;
  end

  always_comb begin
    rd_next       = rd_state;
    bus.ARREADY_a = 1'b0;
    bus.RVALID_a  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        bus.ARREADY_a = !rst;
        if (bus.ARVALID_a) rd_next = R_DATA;
      end
      R_DATA: begin
        bus.RVALID_a = !rst;
        if (bus.RREADY_a && r_last) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  assign ar_hs      = bus.ARVALID_a & bus.ARREADY_a;
  assign r_hs       = bus.RVALID_a & bus.RREADY_a;
  assign ar_cfg_err = !burst_supported(bus.ARBURST_a) || (bus.ARSIZE_a != FULL_SIZE);
  assign r_next     = next_addr(r_addr, r_burst);

  // RAM is fetched only when a new beat is needed, which keeps RDATA frozen on stall
  assign rd_addr = ar_hs ? bus.ARADDR_a : r_next;
  assign rd_zero = ar_hs ? (ar_cfg_err | out_of_range(bus.ARADDR_a))
                         : (r_cfg_err | out_of_range(r_next));
  assign rd_en   = ar_hs | (r_hs & ~r_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_id      <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_burst   <= BURST_FIXED;
      r_cfg_err <= 1'b0;
      r_err     <= 1'b0;
      r_last    <= 1'b0;
    end else if (ar_hs) begin
      r_addr    <= bus.ARADDR_a;
      r_id      <= bus.ARID_a;
      r_len     <= bus.ARLEN_a;
      r_cnt     <= '0;
      r_burst   <= bus.ARBURST_a;
      r_cfg_err <= ar_cfg_err;
      r_err     <= rd_zero;
      r_last    <= (bus.ARLEN_a == 8'd0);
    end else if (r_hs && !r_last) begin
      r_addr <= r_next;
      r_cnt  <= r_cnt + 8'd1;
      r_err  <= rd_zero;
      r_last <= ((r_cnt + 8'd1) == r_len);
    end
  end

  assign bus.RID_a   = r_id;
  assign bus.RRESP_a = r_err ? RESP_SLVERR : RESP_OKAY;
  assign bus.RLAST_a = r_last & bus.RVALID_a;
  assign bus.RDATA_a = rd_data;

  axi4_slave_ram #(
    .data_wid  (data_wid),
    .mem_depth (mem_depth)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (w_addr[IDX_W+BSH-1:BSH]),
    .wr_data (bus.WDATA_a),
    .wr_strb (bus.WSTRB_a),
    .rd_en   (rd_en),
    .rd_addr (rd_addr[IDX_W+BSH-1:BSH]),
    .rd_zero (rd_zero),
    .rd_data (rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_axi4_slave_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_axi4_slave_mem : directed self-checking bench for axi4_slave_mem   |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module tb_axi4_slave_mem;
  import axi4_pkg::*;

  typedef logic [63:0] data_arr_t [16];
  typedef logic [1:0]  resp_arr_t [16];
  typedef logic        last_arr_t [16];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  axi4_slave_mem_if #(.data_wid(64), .adr_wid(32), .id_wid(8)) bus();

  axi4_slave_mem #(
    .data_wid(64), .adr_wid(32), .id_wid(8), .mem_depth(256)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // All bus helpers start and finish on a falling edge
  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    int n = 0;
    bus.AWID_a = id; bus.AWADDR_a = addr; bus.AWLEN_a = len;
    bus.AWBURST_a = burst; bus.AWSIZE_a = size; bus.AWVALID_a = 1'b1;
    while (!bus.AWREADY_a && n < 50) begin @(negedge clk); n++; end
    if (!bus.AWREADY_a) begin
      tests++; fails++; $display("FAIL aw_timeout: AWREADY got 0 required 1");
    end
    @(negedge clk);
    bus.AWVALID_a = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d0, input logic [63:0] step, input logic [7:0] strb,
                        input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      int n = 0;
      bus.WDATA_a = d0 + 64'(i) * step; bus.WSTRB_a = strb;
      bus.WLAST_a = (i == nbeats - 1); bus.WVALID_a = 1'b1;
      while (!bus.WREADY_a && n < 50) begin @(negedge clk); n++; end
      if (!bus.WREADY_a) begin
        tests++; fails++; $display("FAIL w_timeout: WREADY got 0 required 1");
      end
      @(negedge clk);
    end
    bus.WVALID_a = 1'b0; bus.WLAST_a = 1'b0;
  endtask

  task automatic take_b(output logic [7:0] id, output logic [1:0] resp);
    int n = 0;
    bus.BREADY_a = 1'b1;
    while (!bus.BVALID_a && n < 50) begin @(negedge clk); n++; end
    if (!bus.BVALID_a) begin
      tests++; fails++; $display("FAIL b_timeout: BVALID got 0 required 1");
    end
    id = bus.BID_a; resp = bus.BRESP_a;
    @(negedge clk);
    bus.BREADY_a = 1'b0;
  endtask

  task automatic write_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size, input int nbeats,
                             input logic [63:0] d0, input logic [63:0] step, input logic [7:0] strb,
                             output logic [7:0] bid, output logic [1:0] bresp, output logic bv_next);
    send_aw(id, addr, len, burst, size);
    send_w(d0, step, strb, nbeats);
    bv_next = bus.BVALID_a;
    take_b(bid, bresp);
  endtask

  task automatic read_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size,
                            input logic [15:0] pat, input int plen,
                            output data_arr_t data, output resp_arr_t resp, output last_arr_t last,
                            output logic [7:0] rid, output int nbeats, output int unstable,
                            output logic rv_first);
    int          n = 0;
    logic        have = 1'b0;
    logic [74:0] snap = '0;
    logic [74:0] cur;
    nbeats = 0; unstable = 0; rid = '0;
    for (int i = 0; i < 16; i++) begin data[i] = '0; resp[i] = '0; last[i] = 1'b0; end
    bus.ARID_a = id; bus.ARADDR_a = addr; bus.ARLEN_a = len;
    bus.ARBURST_a = burst; bus.ARSIZE_a = size; bus.ARVALID_a = 1'b1;
    while (!bus.ARREADY_a && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.ARVALID_a = 1'b0;
    rv_first = bus.RVALID_a;
    for (int k = 0; k < 200 && nbeats < int'(len) + 1; k++) begin
      bus.RREADY_a = pat[k % plen];
      if (bus.RVALID_a) begin
        cur = {bus.RDATA_a, bus.RRESP_a, bus.RLAST_a, bus.RID_a};
        if (have && cur !== snap) unstable++;
        if (bus.RREADY_a) begin
          if (nbeats < 16) begin
            data[nbeats] = bus.RDATA_a; resp[nbeats] = bus.RRESP_a; last[nbeats] = bus.RLAST_a;
          end
          rid = bus.RID_a; nbeats++; have = 1'b0;
        end else begin
          snap = cur; have = 1'b1;
        end
      end
      @(negedge clk);
    end
    bus.RREADY_a = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.AWREADY_a, bus.ARREADY_a, bus.WREADY_a, bus.BVALID_a, bus.RVALID_a, bus.RLAST_a} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b required 000000",
        {bus.AWREADY_a, bus.ARREADY_a, bus.WREADY_a, bus.BVALID_a, bus.RVALID_a, bus.RLAST_a});
    end
    tests++;
    if ({bus.BID_a, bus.BRESP_a, bus.RID_a, bus.RRESP_a, bus.RDATA_a} !== 84'h0) begin
      fails++; $display("FAIL reset_data: got %h required 0",
        {bus.BID_a, bus.BRESP_a, bus.RID_a, bus.RRESP_a, bus.RDATA_a});
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.AWREADY_a, bus.ARREADY_a} !== 2'b11) begin
      fails++; $display("FAIL reset_release: got %b required 11", {bus.AWREADY_a, bus.ARREADY_a});
    end
  endtask

  task automatic test_incr();
    logic [7:0] bid, rid; logic [1:0] bresp; logic bvn, rvf;
    data_arr_t d; resp_arr_t r; last_arr_t l; int nb, us;
    write_burst(8'h5A, 32'h10, 8'd3, BURST_INCR, 3'd3, 4, 64'h11, 64'h11, 8'hFF, bid, bresp, bvn);
    tests++; if (bvn !== 1'b1) begin fails++; $display("FAIL incr_bvalid_latency: got %b required 1", bvn); end
    tests++; if (bid !== 8'h5A) begin fails++; $display("FAIL incr_bid: got %h required 5a", bid); end
    tests++; if (bresp !== 2'b00) begin fails++; $display("FAIL incr_bresp: got %b required 00", bresp); end
    read_burst(8'hA5, 32'h10, 8'd3, BURST_INCR, 3'd3, 16'hFFFF, 1, d, r, l, rid, nb, us, rvf);
    tests++; if (rvf !== 1'b1) begin fails++; $display("FAIL incr_rvalid_latency: got %b required 1", rvf); end
    tests++; if (nb !== 4) begin fails++; $display("FAIL incr_beats: got %0d required 4", nb); end
    tests++; if (rid !== 8'hA5) begin fails++; $display("FAIL incr_rid: got %h required a5", rid); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (d[i] !== 64'h11 * 64'(i + 1) || r[i] !== 2'b00 || l[i] !== (i == 3)) begin
        fails++; $display("FAIL incr_beat%0d: got data=%h resp=%b last=%b required data=%h resp=00 last=%b",
                          i, d[i], r[i], l[i], 64'h11 * 64'(i + 1), (i == 3));
      end
    end
  endtask

  task automatic test_strobe();
    logic [7:0] bid, rid; logic [1:0] b1, b2; logic bvn, rvf;
    data_arr_t d; resp_arr_t r; last_arr_t l; int nb, us;
    write_burst(8'h01, 32'h0, 8'd0, BURST_INCR, 3'd3, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 8'hFF, bid, b1, bvn);
    write_burst(8'h02, 32'h0, 8'd0, BURST_INCR, 3'd3, 1, 64'h0, 64'h0, 8'h0F, bid, b2, bvn);
    tests++; if ({b1, b2} !== 4'b0) begin fails++; $display("FAIL strobe_bresp: got %b required 0000", {b1, b2}); end
    read_burst(8'h03, 32'h0, 8'd0, BURST_INCR, 3'd3, 16'hFFFF, 1, d, r, l, rid, nb, us, rvf);
    tests++;
    if (d[0] !== 64'hFFFF_FFFF_0000_0000 || l[0] !== 1'b1) begin
      fails++; $display("FAIL strobe_data: got %h last=%b required ffffffff00000000 last=1", d[0], l[0]);
    end
  endtask

  task automatic test_errors();
    logic [7:0] bid, rid; logic [1:0] bresp; logic bvn, rvf;
    data_arr_t d; resp_arr_t r; last_arr_t l; int nb, us;
    write_burst(8'h21, 32'h10, 8'd0, BURST_WRAP, 3'd3, 1, 64'hDEAD, 64'h0, 8'hFF, bid, bresp, bvn);
    tests++; if ({bid, bresp} !== {8'h21, 2'b10}) begin fails++; $display("FAIL err_wrap_bresp: got %h/%b required 21/10", bid, bresp); end
    read_burst(8'h22, 32'h10, 8'd0, BURST_INCR, 3'd3, 16'hFFFF, 1, d, r, l, rid, nb, us, rvf);
    tests++; if (d[0] !== 64'h11 || r[0] !== 2'b00) begin fails++; $display("FAIL err_wrap_mem: got %h/%b required 11/00", d[0], r[0]); end
    write_burst(8'h23, 32'h800, 8'd0, BURST_INCR, 3'd3, 1, 64'hDEAD, 64'h0, 8'hFF, bid, bresp, bvn);
    tests++; if (bresp !== 2'b10) begin fails++; $display("FAIL err_oob_bresp: got %b required 10", bresp); end
    read_burst(8'h24, 32'h0, 8'd0, BURST_INCR, 3'd3, 16'hFFFF, 1, d, r, l, rid, nb, us, rvf);
    tests++; if (d[0] !== 64'hFFFF_FFFF_0000_0000) begin fails++; $display("FAIL err_oob_alias: got %h required ffffffff00000000", d[0]); end
    write_burst(8'h25, 32'h18, 8'd0, BURST_INCR, 3'd2, 1, 64'hDEAD, 64'h0, 8'hFF, bid, bresp, bvn);
    tests++; if (bresp !== 2'b10) begin fails++; $display("FAIL err_size_bresp: got %b required 10", bresp); end
    read_burst(8'h26, 32'h18, 8'd0, BURST_INCR, 3'd3, 16'hFFFF, 1, d, r, l, rid, nb, us, rvf);
    tests++; if (d[0] !== 64'h22) begin fails++; $display("FAIL err_size_mem: got %h required 22", d[0]); end
    write_burst(8'h27, 32'h20, 8'd1, BURST_INCR, 3'd3, 1, 64'h5555, 64'h0, 8'hFF, bid, bresp, bvn);
    tests++; if (bresp !== 2'b10) begin fails++; $display("FAIL err_count_bresp: got %b required 10", bresp); end
    write_burst(8'h28, 32'h7F8, 8'd0, BURST_INCR, 3'd3, 1, 64'hCAFE, 64'h0, 8'hFF, bid, bresp, bvn);
    tests++; if (bresp !== 2'b00) begin fails++; $display("FAIL err_top_bresp: got %b required 00", bresp); end
    read_burst(8'h29, 32'h7F8, 8'd1, BURST_INCR, 3'd3, 16'hFFFF, 1, d, r, l, rid, nb, us, rvf);
    tests++;
    if (nb !== 2 || d[0] !== 64'hCAFE || r[0] !== 2'b00 || l[0] !== 1'b0) begin
      fails++; $display("FAIL err_edge_beat0: got n=%0d %h/%b/%b required 2 cafe/00/0", nb, d[0], r[0], l[0]);
    end
    tests++;
    if (d[1] !== 64'h0 || r[1] !== 2'b10 || l[1] !== 1'b1) begin
      fails++; $display("FAIL err_edge_beat1: got %h/%b/%b required 0/10/1", d[1], r[1], l[1]);
    end
    read_burst(8'h2A, 32'h10, 8'd0, BURST_WRAP, 3'd3, 16'hFFFF, 1, d, r, l, rid, nb, us, rvf);
    tests++; if (d[0] !== 64'h0 || r[0] !== 2'b10) begin fails++; $display("FAIL err_rd_wrap: got %h/%b required 0/10", d[0], r[0]); end
  endtask

  task automatic test_stall();
    logic [7:0] bid, rid; logic [1:0] bresp; logic bvn, rvf;
    data_arr_t d; resp_arr_t r; last_arr_t l; int nb, us;
    write_burst(8'h31, 32'h40, 8'd3, BURST_INCR, 3'd3, 4, 64'hA0, 64'h1, 8'hFF, bid, bresp, bvn);
    // RREADY sequence 1,0,0,1,1,0,1 read from bit 0 upwards
    read_burst(8'h32, 32'h40, 8'd3, BURST_INCR, 3'd3, 16'h0059, 7, d, r, l, rid, nb, us, rvf);
    tests++; if (nb !== 4) begin fails++; $display("FAIL stall_beats: got %0d required 4", nb); end
    tests++; if (us !== 0) begin fails++; $display("FAIL stall_stable: got %0d changes required 0", us); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (d[i] !== 64'hA0 + 64'(i) || l[i] !== (i == 3)) begin
        fails++; $display("FAIL stall_beat%0d: got %h last=%b required %h last=%b", i, d[i], l[i], 64'hA0 + 64'(i), (i == 3));
      end
    end
    send_aw(8'h3C, 32'h60, 8'd0, BURST_INCR, 3'd3);
    send_w(64'hBEEF, 64'h0, 8'hFF, 1);
    for (int c = 0; c < 5; c++) begin
      tests++;
      if ({bus.BVALID_a, bus.AWREADY_a, bus.BID_a, bus.BRESP_a} !== {1'b1, 1'b0, 8'h3C, 2'b00}) begin
        fails++; $display("FAIL b_hold_cycle%0d: got bvalid=%b awready=%b bid=%h bresp=%b required 1 0 3c 00",
                          c, bus.BVALID_a, bus.AWREADY_a, bus.BID_a, bus.BRESP_a);
      end
      @(negedge clk);
    end
    take_b(bid, bresp);
    tests++;
    if ({bus.AWREADY_a, bus.BVALID_a} !== 2'b10) begin
      fails++; $display("FAIL b_release: got awready/bvalid=%b required 10", {bus.AWREADY_a, bus.BVALID_a});
    end
  endtask

  task automatic test_collision();
    logic [7:0] bid, rid; logic [1:0] bresp; logic bvn, rvf;
    data_arr_t d; resp_arr_t r; last_arr_t l; int nb, us;
    write_burst(8'h41, 32'h200, 8'd0, BURST_INCR, 3'd3, 1, 64'h0123, 64'h0, 8'hFF, bid, bresp, bvn);
    send_aw(8'h42, 32'h200, 8'd0, BURST_INCR, 3'd3);
    bus.WDATA_a = 64'h4567; bus.WSTRB_a = 8'hFF; bus.WLAST_a = 1'b1; bus.WVALID_a = 1'b1;
    bus.ARID_a = 8'h43; bus.ARADDR_a = 32'h200; bus.ARLEN_a = 8'd0;
    bus.ARBURST_a = BURST_INCR; bus.ARSIZE_a = 3'd3; bus.ARVALID_a = 1'b1;
    tests++;
    if ({bus.WREADY_a, bus.ARREADY_a} !== 2'b11) begin
      fails++; $display("FAIL coll_ready: got %b required 11", {bus.WREADY_a, bus.ARREADY_a});
    end
    @(negedge clk);
    bus.WVALID_a = 1'b0; bus.WLAST_a = 1'b0; bus.ARVALID_a = 1'b0; bus.RREADY_a = 1'b1;
    tests++;
    if (bus.RVALID_a !== 1'b1 || bus.RDATA_a !== 64'h0123) begin
      fails++; $display("FAIL coll_old_data: got rvalid=%b data=%h required 1 0123", bus.RVALID_a, bus.RDATA_a);
    end
    @(negedge clk);
    bus.RREADY_a = 1'b0;
    take_b(bid, bresp);
    read_burst(8'h44, 32'h200, 8'd0, BURST_INCR, 3'd3, 16'hFFFF, 1, d, r, l, rid, nb, us, rvf);
    tests++; if (d[0] !== 64'h4567) begin fails++; $display("FAIL coll_new_data: got %h required 4567", d[0]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rid; logic rvf;
    data_arr_t d; resp_arr_t r; last_arr_t l; int nb, us;
    send_aw(8'h77, 32'h300, 8'd3, BURST_INCR, 3'd3);
    for (int i = 0; i < 2; i++) begin
      int n = 0;
      bus.WDATA_a = 64'h301 + 64'(i); bus.WSTRB_a = 8'hFF; bus.WLAST_a = 1'b0; bus.WVALID_a = 1'b1;
      while (!bus.WREADY_a && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
    end
    bus.WVALID_a = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.AWREADY_a, bus.ARREADY_a, bus.WREADY_a, bus.BVALID_a, bus.RVALID_a, bus.RLAST_a} !== 6'b0) begin
      fails++; $display("FAIL midrst_ctrl: got %b required 000000",
        {bus.AWREADY_a, bus.ARREADY_a, bus.WREADY_a, bus.BVALID_a, bus.RVALID_a, bus.RLAST_a});
    end
    tests++;
    if ({bus.BID_a, bus.BRESP_a, bus.RID_a, bus.RRESP_a, bus.RDATA_a} !== 84'h0) begin
      fails++; $display("FAIL midrst_data: got bid=%h bresp=%b rid=%h rdata=%h required all 0",
                        bus.BID_a, bus.BRESP_a, bus.RID_a, bus.RDATA_a);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.AWREADY_a, bus.ARREADY_a, bus.BVALID_a} !== 3'b110) begin
      fails++; $display("FAIL midrst_release: got %b required 110", {bus.AWREADY_a, bus.ARREADY_a, bus.BVALID_a});
    end
    read_burst(8'h78, 32'h300, 8'd1, BURST_INCR, 3'd3, 16'hFFFF, 1, d, r, l, rid, nb, us, rvf);
    tests++;
    if (d[0] !== 64'h301 || d[1] !== 64'h302) begin
      fails++; $display("FAIL midrst_persist: got %h %h required 301 302", d[0], d[1]);
    end
  endtask

  initial begin
    bus.AWID_a = '0; bus.AWADDR_a = '0; bus.AWLEN_a = '0; bus.AWSIZE_a = '0;
    bus.AWBURST_a = '0; bus.AWVALID_a = 1'b0;
    bus.WID_a = '0; bus.WDATA_a = '0; bus.WSTRB_a = '0; bus.WLAST_a = 1'b0; bus.WVALID_a = 1'b0;
    bus.BREADY_a = 1'b0;
    bus.ARID_a = '0; bus.ARADDR_a = '0; bus.ARLEN_a = '0; bus.ARSIZE_a = '0;
    bus.ARBURST_a = '0; bus.ARVALID_a = 1'b0;
    bus.RREADY_a = 1'b0;
    test_reset();
    test_incr();
    test_strobe();
    test_errors();
    test_stall();
    test_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
